// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: ALU/MEM/TRAP share a single registered write port.
// A busy scoreboard (COUNT+1 slots; slot COUNT is the supervisor ssp alias) tracks
// destinations with a writeback still outstanding.
// Optional feature: define WB_ARB_RR_EN for ALU/MEM round-robin. Without it, the
// priority is fixed at TRAP > MEM > ALU.
module regfile_wb_arbiter #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned COUNT  = 16,
  parameter int unsigned COUNTP = 4,
  parameter int unsigned SPREG  = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_stall,
  input  logic [2:0]            req_valid,
  output logic [2:0]            req_ready,
  input  logic [3*COUNTP-1:0]   req_addr,
  input  logic [3*WIDTH-1:0]    req_data,
  input  logic [2:0]            req_sup,
  output logic                  rf_write_en,
  output logic [COUNTP-1:0]     rf_write_addr,
  output logic [WIDTH-1:0]      rf_write_data,
  output logic                  rf_write_sup,
  input  logic                  alloc_valid,
  input  logic [COUNTP-1:0]     alloc_addr,
  input  logic                  alloc_sup,
  input  logic                  chk_sup,
  input  logic [COUNTP-1:0]     chk1_addr,
  input  logic [COUNTP-1:0]     chk2_addr,
  output logic                  chk1_busy,
  output logic                  chk2_busy,
  output logic                  alloc_err
);

  localparam int unsigned SlotW = $clog2(COUNT + 1);
  typedef logic [SlotW-1:0] slot_t;

  // Map an architectural register to its scoreboard slot; supervisor SPREG is the extra slot.
  function automatic slot_t slot_of(input logic [COUNTP-1:0] addr, input logic sup);
    if (sup && (addr == COUNTP'(SPREG))) return slot_t'(COUNT);
    return slot_t'(addr);
  endfunction

  logic                wr_en_q, wr_en_d;
  logic [COUNTP-1:0]   wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]    wr_data_q, wr_data_d;
  logic                wr_sup_q, wr_sup_d;
  logic [COUNT:0]      busy_q, busy_d;
  logic                alloc_err_q, alloc_err_d;

  logic                xfer;
  logic [COUNTP-1:0]   win_addr;
  logic [WIDTH-1:0]    win_data;
  logic                win_sup;
  slot_t               clr_slot, alloc_slot;

`ifdef WB_ARB_RR_EN
  // 1 = MEM won the last ALU/MEM transfer, so ALU goes first on the next contention.
  logic rr_mem_last_q, rr_mem_last_d;
`endif

  // Grant: stall blocks everything, TRAP always wins, then ALU/MEM by policy.
  always_comb begin
    req_ready = 3'b000;
    if (!wb_stall) begin
      if (req_valid[2]) begin
        req_ready = 3'b100;
      end else if (req_valid[0] && req_valid[1]) begin
`ifdef WB_ARB_RR_EN
        req_ready = rr_mem_last_q ? 3'b001 : 3'b010;
`else
        req_ready = 3'b010;
`endif
      end else if (req_valid[1]) begin
        req_ready = 3'b010;
      end else if (req_valid[0]) begin
        req_ready = 3'b001;
      end
    end
  end

  // Select the winning source's payload.
  always_comb begin
    win_addr = '0;
    win_data = '0;
    win_sup  = 1'b0;
    unique case (req_ready)
      3'b001: begin
        win_addr = req_addr[0*COUNTP +: COUNTP];
        win_data = req_data[0*WIDTH +: WIDTH];
        win_sup  = req_sup[0];
      end
      3'b010: begin
        win_addr = req_addr[1*COUNTP +: COUNTP];
        win_data = req_data[1*WIDTH +: WIDTH];
        win_sup  = req_sup[1];
      end
      3'b100: begin
        win_addr = req_addr[2*COUNTP +: COUNTP];
        win_data = req_data[2*WIDTH +: WIDTH];
        win_sup  = req_sup[2];
      end
      default: ;
    endcase
  end

  assign xfer       = |req_ready;
  assign clr_slot   = slot_of(win_addr, win_sup);
  assign alloc_slot = slot_of(alloc_addr, alloc_sup);

  // Next state: write port, scoreboard (set beats clear) and alloc error pulse.
  always_comb begin
    wr_en_d   = xfer;
    wr_addr_d = xfer ? win_addr : wr_addr_q;
    wr_data_d = xfer ? win_data : wr_data_q;
    wr_sup_d  = xfer ? win_sup  : wr_sup_q;

    busy_d = busy_q;
    if (xfer)        busy_d[clr_slot]   = 1'b0;
    if (alloc_valid) busy_d[alloc_slot] = 1'b1;

    alloc_err_d = alloc_valid && busy_q[alloc_slot] && !(xfer && (clr_slot == alloc_slot));
  end

`ifdef WB_ARB_RR_EN
  // Pointer moves only on an ALU/MEM transfer; TRAP grants leave it alone.
  always_comb begin
    rr_mem_last_d = rr_mem_last_q;
    if (req_ready[0])      rr_mem_last_d = 1'b0;
    else if (req_ready[1]) rr_mem_last_d = 1'b1;
  end
`endif

  // State registers; async reset discards any in-flight write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      wr_sup_q      <= 1'b0;
      busy_q        <= '0;
      alloc_err_q   <= 1'b0;
`ifdef WB_ARB_RR_EN
      rr_mem_last_q <= 1'b1;
`endif
    end else begin
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      wr_sup_q      <= wr_sup_d;
      busy_q        <= busy_d;
      alloc_err_q   <= alloc_err_d;
`ifdef WB_ARB_RR_EN
      rr_mem_last_q <= rr_mem_last_d;
`endif
    end
  end

  assign rf_write_en   = wr_en_q;
  assign rf_write_addr = wr_addr_q;
  assign rf_write_data = wr_data_q;
  assign rf_write_sup  = wr_sup_q;
  assign alloc_err     = alloc_err_q;
  assign chk1_busy     = busy_q[slot_of(chk1_addr, chk_sup)];
  assign chk2_busy     = busy_q[slot_of(chk2_addr, chk_sup)];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by randomized
// traffic, all compared against a behavioural model of the writeback/scoreboard rules.
module tb_regfile_wb_arbiter;

  localparam int W  = 64;
  localparam int N  = 16;
  localparam int AW = 4;
`ifdef WB_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            wb_stall;
  logic [2:0]      req_valid;
  logic [2:0]      req_ready;
  logic [3*AW-1:0] req_addr;
  logic [3*W-1:0]  req_data;
  logic [2:0]      req_sup;
  logic            rf_write_en;
  logic [AW-1:0]   rf_write_addr;
  logic [W-1:0]    rf_write_data;
  logic            rf_write_sup;
  logic            alloc_valid;
  logic [AW-1:0]   alloc_addr;
  logic            alloc_sup;
  logic            chk_sup;
  logic [AW-1:0]   chk1_addr;
  logic [AW-1:0]   chk2_addr;
  logic            chk1_busy;
  logic            chk2_busy;
  logic            alloc_err;

  regfile_wb_arbiter #(
    .WIDTH (W),
    .COUNT (N),
    .COUNTP(AW),
    .SPREG (15)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_stall     (wb_stall),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_sup      (req_sup),
    .rf_write_en  (rf_write_en),
    .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data),
    .rf_write_sup (rf_write_sup),
    .alloc_valid  (alloc_valid),
    .alloc_addr   (alloc_addr),
    .alloc_sup    (alloc_sup),
    .chk_sup      (chk_sup),
    .chk1_addr    (chk1_addr),
    .chk2_addr    (chk2_addr),
    .chk1_busy    (chk1_busy),
    .chk2_busy    (chk2_busy),
    .alloc_err    (alloc_err)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model state.
  bit            m_busy[N+1];
  bit            m_en, m_sup, m_err;
  bit            m_last_mem;
  logic [AW-1:0] m_addr;
  logic [W-1:0]  m_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int slot(input logic [AW-1:0] a, input logic s);
    return (s && a == 4'd15) ? N : int'(a);
  endfunction

  // Which source should be granted given current inputs, or -1 for none.
  function automatic int winner();
    if (wb_stall) return -1;
    if (req_valid[2]) return 2;
    if (req_valid[0] && req_valid[1]) return (RR && m_last_mem) ? 0 : 1;
    if (req_valid[1]) return 1;
    if (req_valid[0]) return 0;
    return -1;
  endfunction

  task automatic m_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_en = 0; m_sup = 0; m_err = 0; m_last_mem = 1;
    m_addr = '0; m_data = '0;
  endtask

  task automatic clear_inputs();
    wb_stall = 0; req_valid = '0; req_addr = '0; req_data = '0; req_sup = '0;
    alloc_valid = 0; alloc_addr = '0; alloc_sup = 0;
    chk_sup = 0; chk1_addr = '0; chk2_addr = '0;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [W-1:0] d,
                         input logic s);
    req_valid[i] = 1'b1;
    req_addr[i*AW +: AW] = a;
    req_data[i*W +: W] = d;
    req_sup[i] = s;
  endtask

  // Check every output against the model at the falling edge.
  task automatic sample();
    int w;
    logic [2:0] er;
    @(negedge clk);
    w = winner();
    er = (w < 0) ? 3'b000 : 3'(1 << w);
    chk("req_ready", req_ready, er);
    chk("rf_write_en", rf_write_en, m_en);
    chk("rf_write_addr", rf_write_addr, m_addr);
    chk("rf_write_data", rf_write_data, m_data);
    chk("rf_write_sup", rf_write_sup, m_sup);
    chk("alloc_err", alloc_err, m_err);
    chk("chk1_busy", chk1_busy, m_busy[slot(chk1_addr, chk_sup)]);
    chk("chk2_busy", chk2_busy, m_busy[slot(chk2_addr, chk_sup)]);
  endtask

  // Advance the model across the rising edge; a transferred requester then drops valid.
  task automatic tick();
    int w, as;
    w  = winner();
    as = slot(alloc_addr, alloc_sup);
    m_err = alloc_valid && m_busy[as] &&
            !(w >= 0 && slot(req_addr[w*AW +: AW], req_sup[w]) == as);
    if (w >= 0) begin
      m_en = 1;
      m_addr = req_addr[w*AW +: AW];
      m_data = req_data[w*W +: W];
      m_sup = req_sup[w];
      m_busy[slot(m_addr, m_sup)] = 1'b0;
      if (w == 0) m_last_mem = 0;
      if (w == 1) m_last_mem = 1;
    end else begin
      m_en = 0;
    end
    if (alloc_valid) m_busy[as] = 1'b1;
    @(posedge clk);
    #1;
    if (w >= 0) req_valid[w] = 1'b0;
  endtask

  initial begin
    clear_inputs();
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state.
    sample();
    chk("rst_en", rf_write_en, 0);
    chk("rst_ready", req_ready, 3'b000);
    chk("rst_err", alloc_err, 0);
    chk("rst_busy", chk1_busy, 0);
    tick();

    // Contention: TRAP first, then ALU/MEM by policy, back to back.
    set_req(0, 4'd1, 64'hA1, 0);
    set_req(1, 4'd2, 64'hB2, 0);
    set_req(2, 4'd4, 64'hC4, 1);
    sample(); chk("cont_g0", req_ready, 3'b100); tick();
    sample(); chk("cont_g1", req_ready, RR ? 3'b001 : 3'b010);
    chk("cont_wb0", rf_write_addr, 4'd4); tick();
    sample(); chk("cont_g2", req_ready, RR ? 3'b010 : 3'b001);
    chk("cont_wb1_en", rf_write_en, 1);
    chk("cont_wb1", rf_write_addr, RR ? 4'd1 : 4'd2); tick();
    sample(); chk("cont_wb2_en", rf_write_en, 1);
    chk("cont_wb2", rf_write_addr, RR ? 4'd2 : 4'd1); tick();
    sample(); chk("cont_idle", rf_write_en, 0); tick();

    // Single ALU write, latency 1.
    set_req(0, 4'd3, 64'h1234, 0);
    sample(); chk("alu_ready", req_ready, 3'b001); tick();
    sample(); chk("alu_en", rf_write_en, 1);
    chk("alu_addr", rf_write_addr, 4'd3);
    chk("alu_data", rf_write_data, 64'h1234); tick();
    sample(); chk("alu_en_off", rf_write_en, 0);
    chk("alu_hold", rf_write_data, 64'h1234); tick();

    // Stall for three cycles with MEM pending.
    set_req(1, 4'd6, 64'h66, 0);
    wb_stall = 1;
    for (int i = 0; i < 3; i++) begin
      sample(); chk("stall_ready", req_ready, 3'b000); chk("stall_en", rf_write_en, 0); tick();
    end
    wb_stall = 0;
    sample(); chk("unstall_ready", req_ready, 3'b010); tick();
    sample(); chk("unstall_en", rf_write_en, 1); tick();

    // Supervisor r15 aliasing.
    alloc_valid = 1; alloc_addr = 4'd15; alloc_sup = 1;
    sample(); tick();
    alloc_sup = 0;
    sample(); tick();
    alloc_valid = 0;
    chk1_addr = 4'd15; chk2_addr = 4'd15; chk_sup = 1;
    sample(); chk("ssp_busy_sup", chk1_busy, 1);
    chk_sup = 0;
    #1; chk("r15_busy_user", chk1_busy, 1);
    set_req(1, 4'd15, 64'h55, 1);
    tick();
    sample(); tick();
    chk_sup = 1;
    sample(); chk("ssp_cleared", chk1_busy, 0);
    chk_sup = 0;
    #1; chk("r15_still_busy", chk1_busy, 1);
    tick();

    // Double alloc of r5 without a write.
    alloc_valid = 1; alloc_addr = 4'd5; alloc_sup = 0;
    sample(); tick();
    sample(); tick();
    alloc_valid = 0;
    sample(); chk("dbl_err_pulse", alloc_err, 1); tick();
    sample(); chk("dbl_err_clear", alloc_err, 0); tick();

    // Set/clear collision on r7.
    alloc_valid = 1; alloc_addr = 4'd7;
    sample(); tick();
    set_req(0, 4'd7, 64'h77, 0);
    chk1_addr = 4'd7;
    sample(); tick();
    alloc_valid = 0;
    sample(); chk("coll_busy", chk1_busy, 1); chk("coll_err", alloc_err, 0); tick();

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!req_valid[i] && ($urandom_range(0, (i == 2) ? 5 : 1) == 0))
          set_req(i, 4'($urandom_range(0, 15)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      end
      wb_stall    = ($urandom_range(0, 4) == 0);
      alloc_valid = ($urandom_range(0, 2) == 0);
      alloc_addr  = 4'($urandom_range(0, 15));
      alloc_sup   = 1'($urandom_range(0, 1));
      chk_sup     = 1'($urandom_range(0, 1));
      chk1_addr   = 4'($urandom_range(0, 15));
      chk2_addr   = 4'($urandom_range(0, 15));
      sample();
      tick();
    end

    // Async reset while a write is being presented.
    clear_inputs();
    set_req(2, 4'd9, 64'h99, 0);
    sample(); tick();
    chk("pre_rst_en", rf_write_en, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_en", rf_write_en, 0);
    chk("async_rst_data", rf_write_data, 0);
    m_reset();
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sample(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
